rv_ctrl_alu: RTL and testbench

RV_CTRL_ALU -- requirements
Module: rv_ctrl_alu

---
 rtl/rv_ctrl_alu.sv | 184 ++++++++++++++++++
 tb/tb_rv_ctrl_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rv_ctrl_alu.sv
// Two-state multicycle control unit and single-cycle RV32I ALU.
// Control word is decoded combinationally from the FSM state and opcode.
module rv_ctrl_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [2:0]  alu_ctrl,
  input  logic        alu_alt,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  output logic [17:0] control_signals,
  output logic [1:0]  cs_alu_ctrl_sel,
  output logic [1:0]  cs_alu_b_sel,
  output logic        cs_reg_write_rd_en,
  output logic [2:0]  cs_reg_write_rd_sel,
  output logic        cs_mem_read_en,
  output logic [1:0]  cs_mem_addr_sel,
  output logic        cs_mem_width_sel,
  output logic        cs_alu_twos_b,
  output logic        cs_inst_write_en,
  output logic        cs_mem_write_en,
  output logic [2:0]  cs_pc_mux_sel
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] alu_ctrl_sel;
    logic [1:0] alu_b_sel;
    logic       rd_en;
    logic [2:0] rd_sel;
    logic       mem_read_en;
    logic [1:0] mem_addr_sel;
    logic       mem_width_sel;
    logic       alu_twos_b;
    logic       inst_write_en;
    logic       mem_write_en;
    logic [2:0] pc_mux_sel;
  } ctrl_word_t;

  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  state_t     state, state_nxt;
  ctrl_word_t cw;
  logic [4:0] shamt;

  assign shamt = alu_b[4:0];

  // ALU: pure combinational datapath, shifts use only B[4:0]
  always_comb begin
    alu_out = '0;
    unique case (alu_ctrl)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a << shamt;
      3'b010: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'b011: alu_out = {31'd0, alu_a < alu_b};
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = alu_alt ? 32'($signed(alu_a) >>> shamt)
                                : alu_a >> shamt;
      3'b110: alu_out = alu_a | alu_b;
      3'b111: alu_out = alu_a & alu_b;
      default: alu_out = '0;
    endcase
  end

  assign alu_zero = (alu_out == 32'd0);

  // State register: FETCH on reset, otherwise alternate
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next state: one instruction every two cycles
  always_comb begin
    state_nxt = FETCH;
    unique case (state)
      FETCH: state_nxt = EXEC;
      EXEC:  state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Control word: reset blanks everything so an aborted EXEC writes nothing
  always_comb begin
    cw = '0;
    if (!reset) begin
      unique case (state)
        FETCH: begin
          cw.mem_read_en   = 1'b1;
          cw.inst_write_en = 1'b1;
        end
        EXEC: begin
          unique case (1'b1)
            (opcode == OP_OP): begin
              cw.alu_twos_b = 1'b1;
              cw.rd_en      = 1'b1;
              cw.pc_mux_sel = 3'd1;
            end
            (opcode == OP_IMM): begin
              cw.alu_b_sel  = 2'd1;
              cw.rd_en      = 1'b1;
              cw.pc_mux_sel = 3'd1;
            end
            (opcode == OP_LOAD): begin
              cw.alu_ctrl_sel  = 2'd2;
              cw.alu_b_sel     = 2'd1;
              cw.mem_read_en   = 1'b1;
              cw.mem_addr_sel  = 2'd1;
              cw.mem_width_sel = 1'b1;
              cw.rd_en         = 1'b1;
              cw.rd_sel        = 3'd1;
              cw.pc_mux_sel    = 3'd1;
            end
            (opcode == OP_STORE): begin
              cw.alu_ctrl_sel  = 2'd2;
              cw.alu_b_sel     = 2'd2;
              cw.mem_write_en  = 1'b1;
              cw.mem_addr_sel  = 2'd1;
              cw.mem_width_sel = 1'b1;
              cw.pc_mux_sel    = 3'd1;
            end
            (opcode == OP_BRANCH): begin
              cw.alu_ctrl_sel = 2'd1;
              cw.alu_twos_b   = 1'b1;
              cw.pc_mux_sel   = 3'd4;
            end
            (opcode == OP_LUI): begin
              cw.rd_en      = 1'b1;
              cw.rd_sel     = 3'd4;
              cw.pc_mux_sel = 3'd1;
            end
            (opcode == OP_AUIPC): begin
              cw.rd_en      = 1'b1;
              cw.rd_sel     = 3'd5;
              cw.pc_mux_sel = 3'd1;
            end
            (opcode == OP_JAL): begin
              cw.rd_en      = 1'b1;
              cw.rd_sel     = 3'd3;
              cw.pc_mux_sel = 3'd2;
            end
            (opcode == OP_JALR): begin
              cw.alu_ctrl_sel = 2'd2;
              cw.alu_b_sel    = 2'd1;
              cw.rd_en        = 1'b1;
              cw.rd_sel       = 3'd3;
              cw.pc_mux_sel   = 3'd3;
            end
            default: cw.pc_mux_sel = 3'd6;
          endcase
        end
        default: cw = '0;
      endcase
    end
  end

  assign control_signals     = cw;
  assign cs_alu_ctrl_sel     = cw.alu_ctrl_sel;
  assign cs_alu_b_sel        = cw.alu_b_sel;
  assign cs_reg_write_rd_en  = cw.rd_en;
  assign cs_reg_write_rd_sel = cw.rd_sel;
  assign cs_mem_read_en      = cw.mem_read_en;
  assign cs_mem_addr_sel     = cw.mem_addr_sel;
  assign cs_mem_width_sel    = cw.mem_width_sel;
  assign cs_alu_twos_b       = cw.alu_twos_b;
  assign cs_inst_write_en    = cw.inst_write_en;
  assign cs_mem_write_en     = cw.mem_write_en;
  assign cs_pc_mux_sel       = cw.pc_mux_sel;

endmodule

// File: tb/tb_rv_ctrl_alu.sv
// Directed bench for rv_ctrl_alu: ALU vector table, opcode decode
// table, and hand-written reset/abort sequences.
module tb_rv_ctrl_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  opcode;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic        alu_alt;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [17:0] control_signals;
  logic [1:0]  cs_alu_ctrl_sel, cs_alu_b_sel, cs_mem_addr_sel;
  logic        cs_reg_write_rd_en, cs_mem_read_en, cs_mem_width_sel;
  logic [2:0]  cs_reg_write_rd_sel, cs_pc_mux_sel;
  logic        cs_alu_twos_b, cs_inst_write_en, cs_mem_write_en;

  int total = 0;
  int bad = 0;

  localparam logic [17:0] CW_FETCH = 18'h00210;

  always #5 clk = ~clk;

  rv_ctrl_alu dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_alt(alu_alt), .alu_out(alu_out), .alu_zero(alu_zero),
    .control_signals(control_signals),
    .cs_alu_ctrl_sel(cs_alu_ctrl_sel), .cs_alu_b_sel(cs_alu_b_sel),
    .cs_reg_write_rd_en(cs_reg_write_rd_en),
    .cs_reg_write_rd_sel(cs_reg_write_rd_sel),
    .cs_mem_read_en(cs_mem_read_en), .cs_mem_addr_sel(cs_mem_addr_sel),
    .cs_mem_width_sel(cs_mem_width_sel), .cs_alu_twos_b(cs_alu_twos_b),
    .cs_inst_write_en(cs_inst_write_en),
    .cs_mem_write_en(cs_mem_write_en), .cs_pc_mux_sel(cs_pc_mux_sel)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [17:0] cw;
  } dec_vec_t;

  alu_vec_t av[14];
  dec_vec_t dv[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    av[0]  = '{3'b010, 1'b0, 32'h80000000, 32'h1, 32'h1};
    av[1]  = '{3'b011, 1'b0, 32'h80000000, 32'h1, 32'h0};
    av[2]  = '{3'b101, 1'b1, 32'h80000000, 32'h1, 32'hC0000000};
    av[3]  = '{3'b101, 1'b0, 32'h80000000, 32'h1, 32'h40000000};
    av[4]  = '{3'b000, 1'b0, 32'h5, 32'hFFFFFFFB, 32'h0};
    av[5]  = '{3'b001, 1'b0, 32'h5, 32'h21, 32'hA};
    av[6]  = '{3'b000, 1'b0, 32'h7, 32'h3, 32'hA};
    av[7]  = '{3'b100, 1'b0, 32'hF0F0, 32'hFF00, 32'h0FF0};
    av[8]  = '{3'b110, 1'b0, 32'hF0F0, 32'hFF00, 32'hFFF0};
    av[9]  = '{3'b111, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000};
    av[10] = '{3'b010, 1'b0, 32'h1, 32'h80000000, 32'h0};
    av[11] = '{3'b011, 1'b0, 32'h1, 32'h80000000, 32'h1};
    av[12] = '{3'b101, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    av[13] = '{3'b101, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h1};

    dv[0]  = '{5'b01100, 18'h02021};
    dv[1]  = '{5'b00100, 18'h06001};
    dv[2]  = '{5'b00000, 18'h266C1};
    dv[3]  = '{5'b01000, 18'h280C9};
    dv[4]  = '{5'b11000, 18'h10024};
    dv[5]  = '{5'b01101, 18'h03001};
    dv[6]  = '{5'b00101, 18'h03401};
    dv[7]  = '{5'b11011, 18'h02C02};
    dv[8]  = '{5'b11001, 18'h26C03};
    dv[9]  = '{5'b11111, 18'h00006};
    dv[10] = '{5'b11100, 18'h00006};

    reset = 1'b1;
    opcode = 5'b01100;
    alu_a = 32'h0;
    alu_b = 32'h0;
    alu_ctrl = 3'b000;
    alu_alt = 1'b0;

    tick();
    tick();
    chk("reset_cw", 32'(control_signals), 32'h0);

    for (int i = 0; i < 14; i++) begin
      alu_ctrl = av[i].ctrl;
      alu_alt  = av[i].alt;
      alu_a    = av[i].a;
      alu_b    = av[i].b;
      #1;
      chk($sformatf("alu_out[%0d]", i), alu_out, av[i].exp);
      chk($sformatf("alu_zero[%0d]", i), 32'(alu_zero),
          32'(av[i].exp == 32'h0));
    end

    reset = 1'b0;
    #1;
    chk("first_fetch", 32'(control_signals), 32'(CW_FETCH));
    tick();
    chk("first_exec_op", 32'(control_signals), 32'h02021);
    tick();

    for (int i = 0; i < 11; i++) begin
      opcode = dv[i].op;
      #1;
      chk($sformatf("fetch_cw[%0d]", i), 32'(control_signals),
          32'(CW_FETCH));
      tick();
      chk($sformatf("exec_cw[%0d]", i), 32'(control_signals),
          32'(dv[i].cw));
      chk($sformatf("rw_excl[%0d]", i),
          32'(cs_mem_read_en & cs_mem_write_en), 32'h0);
      tick();
    end

    opcode = 5'b11111;
    tick();
    chk("illegal_pc", 32'(cs_pc_mux_sel), 32'd6);
    chk("illegal_en", 32'({cs_reg_write_rd_en, cs_mem_read_en,
        cs_inst_write_en, cs_mem_write_en}), 32'h0);
    tick();
    chk("after_illegal", 32'(control_signals), 32'(CW_FETCH));

    opcode = 5'b01000;
    tick();
    chk("store_we", 32'(cs_mem_write_en), 32'h1);
    chk("store_addr", 32'(cs_mem_addr_sel), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_we", 32'(cs_mem_write_en), 32'h0);
    chk("abort_cw", 32'(control_signals), 32'h0);
    tick();
    chk("abort_hold", 32'(control_signals), 32'h0);
    reset = 1'b0;
    #1;
    chk("abort_fetch", 32'(control_signals), 32'(CW_FETCH));
    tick();
    chk("abort_exec", 32'(control_signals), 32'h280C9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
